hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage (F/D/E/M/W) pipelined processor. It generates operand-forwarding selects, per-stage stall and flush controls for load-use hazards, PC-write hazards and taken branches. It also runs a small FSM that freezes the pipeline while data memory is not ready, with a timeout error. It sits beside the `controller` and datapath and drives the enable/clear inputs of the pipeline registers.

## Interface
- `TIMEOUT`, 16: maximum consecutive memory-wait cycles before error (≥2).
- `CNT_W`, 16: width of the stall performance counter.

- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `RA1D`, `RA2D` in 4 each: source registers in Decode.
- `RA1E`, `RA2E` in 4 each: source registers in Execute.
- `WA3E`, `WA3M`, `WA3W` in 4 each: destination register in E/M/W.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1 each: destination write enables, already condition-qualified.
- `MemtoRegE` in 1: load instruction in Execute.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW` in 1 each: PC-writing instruction in each stage.
- `BranchTakenE` in 1: branch resolved taken in Execute.
- `MemReqM` in 1: Memory stage is accessing data memory.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `ForwardAE`, `ForwardBE` out 2 each: 00 register file, 01 ResultW, 10 ALUResultM.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold the pipeline register feeding that stage.
- `FlushD`, `FlushE`, `FlushW` out 1 each: clear that pipeline register to a bubble.
- `MemErr` out 1: sticky memory-timeout error.
- `StallCount` out CNT_W: saturating count of cycles with any stall.

## Operation
- **Forwarding.**
  - ForwardAE = 10 if `RA1E==WA3E_M` and `RegWriteM`.
  - Else ForwardAE = 01 if `RA1E==WA3W` and `RegWriteW`.
  - Else ForwardAE = 00.
  - M has priority over W. ForwardBE uses the same rule on `RA2E`.
- **Load-use.** ldrStall = `MemtoRegE` & `RegWriteE` & (`RA1D==WA3E` | `RA2D==WA3E`).
- **PC pending.** PCWrPending = `PCSrcD` | `PCSrcE` | `PCSrcM`.
- **Base controls** (memory FSM in IDLE and `MemReadyM`):
  - StallF = ldrStall | PCWrPending.
  - StallD = ldrStall.
  - StallE = StallM = 0.
  - FlushD = PCWrPending | `PCSrcW` | `BranchTakenE`.
  - FlushE = ldrStall | `BranchTakenE`.
  - FlushW = 0.
- **MemStall** = `MemReqM` & !`MemReadyM` & !`MemErr`.
- **When MemStall is asserted:**
  - StallF, StallD, StallE and StallM are all 1.
  - FlushW = 1, which inserts a bubble into W so the instruction in W retires exactly once.
  - FlushD = FlushE = 0; all base controls are masked.
  - Forwarding outputs are still computed normally.
- **Memory FSM states:** IDLE, WAIT, ERR.
  - IDLE→WAIT when MemStall; the wait counter loads to 1.
  - WAIT stays in WAIT while MemStall; the counter increments.
  - WAIT→ERR when the counter reaches `TIMEOUT` with MemStall still high.
  - WAIT→IDLE when `MemReadyM`.
  - ERR is terminal until reset. In ERR, `MemErr`=1, MemStall is forced 0, and base controls apply.
- **StallCount** increments on every cycle where any Stall* output is 1. It saturates at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current FSM state. There is no added latency.
- FSM state, wait counter, `MemErr` and `StallCount` update on the rising edge.
- **Reset** (`reset`=0 sampled at an edge):
  - Next state is IDLE, wait counter 0, `MemErr`=0, `StallCount`=0.
  - While `reset`=0, outputs are forced: all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
  - Reset asserted during WAIT abandons the wait. No error is raised.
- **Load-use:** exactly one stall cycle, because the load moves to M on the next edge.
- **PC write:** F stays stalled for 3 cycles (instruction in D, E, M), then `PCSrcW` flushes D for 1 more cycle.
- **MemReadyM timing:** a `MemReadyM` pulse on the same cycle as a new `MemReqM` gives zero stall cycles.
- **Timeout boundary:** `TIMEOUT` wait cycles are stalled. `MemErr` rises on the edge ending cycle `TIMEOUT` and releases the stall from the next cycle.
- **Simultaneous events:**
  - A memory stall overrides a load-use stall, a branch flush or a PC-pending stall in the same cycle.
  - Those hazards are re-evaluated once the stall releases, because the pipeline is frozen.

## Test plan
- **Forwarding priority:** `RA1E`=3, `WA3M`=3, `RegWriteM`=1, `WA3W`=3, `RegWriteW`=1 → ForwardAE=10. Drop `RegWriteM` → 01. `RA2E`=5 with no match → ForwardBE=00.
- **Load-use:** `MemtoRegE`=`RegWriteE`=1, `WA3E`=2, `RA2D`=2 → StallF=StallD=FlushE=1 for one cycle; `WA3E`=7 → all 0.
- **PC pending:**
  - Walk `PCSrc` D→E→M→W on 4 consecutive cycles → StallF=1 for 3 cycles.
  - FlushD=1 for all 4 cycles.
  - `BranchTakenE`=1 alone → FlushD=FlushE=1.
- **Memory wait:**
  - `MemReqM`=1, `MemReadyM`=0 for 3 cycles, then 1 → StallF/D/E/M=FlushW=1 for exactly 3 cycles, then IDLE.
  - `StallCount`=3.
  - A concurrent `BranchTakenE` shows FlushE=0 during the stall.
- **Timeout:**
  - `TIMEOUT`=4, `MemReadyM` held 0 → 4 stall cycles.
  - `MemErr`=1 from cycle 5 and stalls drop.
  - `reset`=0 for one edge → `MemErr`=0, `StallCount`=0, FlushD/E/W=1 during reset.
- **Counter saturation:** `CNT_W`=4 with a continuous load-use stall for 20 cycles → `StallCount`=15 and holds.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage F/D/E/M/W core.
// Produces operand-forwarding selects, per-stage stall/flush controls for
// load-use, PC-write and taken-branch hazards, and freezes the pipeline while
// data memory is not ready (with a sticky timeout error).
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E  source registers in Decode / Execute
//   WA3E/WA3M/WA3W        destination registers in E/M/W
//   RegWriteE/M/W         destination write enables
//   MemtoRegE             load in Execute
//   PCSrcD/E/M/W          PC-writing instruction in each stage
//   BranchTakenE          branch resolved taken in Execute
//   MemReqM, MemReadyM    data memory request / completion in Memory
//   ForwardAE/BE          00 regfile, 01 ResultW, 10 ALUResultM
//   StallF/D/E/M          hold the pipeline register feeding that stage
//   FlushD/E/W            clear that pipeline register to a bubble
//   MemErr                sticky memory-timeout error (registered)
//   StallCount            saturating count of stalled cycles (registered)
module hazard_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memState_t;

  memState_t         state;
  memState_t         nextState;
  logic [WCNT_W-1:0] waitCnt;
  logic [WCNT_W-1:0] nextWaitCnt;

  logic ldrStall;
  logic pcWrPending;
  logic memStall;
  logic anyStall;

  // Forwarding select for one Execute source operand; M beats W.
  function automatic logic [1:0] fwdSel(input logic [3:0] ra);
    if (RegWriteM && (ra == WA3M))      fwdSel = 2'b10;
    else if (RegWriteW && (ra == WA3W)) fwdSel = 2'b01;
    else                                fwdSel = 2'b00;
  endfunction

  assign ldrStall    = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcWrPending = PCSrcD | PCSrcE | PCSrcM;
  // Once in error the memory stall is released so the pipeline can drain.
  assign memStall    = MemReqM & ~MemReadyM & ~MemErr;
  assign anyStall    = StallF | StallD | StallE | StallM;

  // State, wait counter, sticky error and performance counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      MemErr     <= 1'b0;
      StallCount <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      MemErr  <= (nextState == ERR);
      if (anyStall && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= CNT_W'(StallCount + 1'b1);
      end
    end
  end

  // Memory FSM next state plus all stall/flush/forward controls.
  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;

    case (state)
      IDLE: begin
        if (memStall) begin
          nextState   = WAIT;
          nextWaitCnt = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (memStall) begin
          // Counter holds the number of stalled cycles so far, this one included next.
          nextWaitCnt = WCNT_W'(waitCnt + 1'b1);
          if (waitCnt >= WCNT_W'(TIMEOUT - 1)) begin
            nextState = ERR;
          end
        end else begin
          nextState   = IDLE;
          nextWaitCnt = '0;
        end
      end
      ERR: begin
        nextState = ERR;
      end
      default: begin
        nextState   = IDLE;
        nextWaitCnt = '0;
      end
    endcase

    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwdSel(RA1E);
      ForwardBE = fwdSel(RA2E);
      if (memStall) begin
        // Freeze everything; bubble into W so the W instruction retires once.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldrStall | pcWrPending;
        StallD = ldrStall;
        FlushD = pcWrPending | PCSrcW | BranchTakenE;
        FlushE = ldrStall | BranchTakenE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TIMEOUT=4, CNT_W=4).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW, MemErr;
  logic [3:0] StallCount;

  int nChecks = 0;
  int nFail   = 0;
  logic [3:0] expCnt = 4'd0;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;   // StallF, StallD, StallE, StallM
    logic [2:0] fl;   // FlushD, FlushE, FlushW
    logic       me;
    logic [3:0] sc;
  } expT;

  expT q[$];

  hazard_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic expT mk(input logic [1:0] fa, input logic [1:0] fb,
                             input logic [3:0] st, input logic [2:0] fl,
                             input logic me);
    expT e;
    e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.me = me; e.sc = expCnt;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: queue the expectation, compare mid-cycle, advance to next negedge.
  task automatic cyc(input expT e);
    expT got;
    q.push_back(e);
    #1;
    got = q.pop_front();
    chk("ForwardAE",  {2'b00, ForwardAE}, {2'b00, got.fa});
    chk("ForwardBE",  {2'b00, ForwardBE}, {2'b00, got.fb});
    chk("Stall",      {StallF, StallD, StallE, StallM}, got.st);
    chk("Flush",      {1'b0, FlushD, FlushE, FlushW}, {1'b0, got.fl});
    chk("MemErr",     {3'b000, MemErr}, {3'b000, got.me});
    chk("StallCount", StallCount, got.sc);
    if (!reset) expCnt = 4'd0;
    else if ((|got.st) && expCnt != 4'hF) expCnt = expCnt + 4'd1;
    @(negedge clk);
  endtask

  task automatic clr();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic doReset();
    clr();
    reset = 1'b0;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b111, MemErr === 1'b1 ? 1'b1 : 1'b0));
    reset = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    @(negedge clk);
    // Reset state and forced outputs.
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0));
    reset = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    // Forwarding priority.
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1; RA2E = 4'd5;
    cyc(mk(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0));
    RegWriteM = 1'b0;
    cyc(mk(2'b01, 2'b00, 4'b0000, 3'b000, 1'b0));
    RA2E = 4'd3;
    cyc(mk(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0));
    clr();

    // Load-use: one stall, then no hazard.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd1;
    cyc(mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    WA3E = 4'd7;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    clr();

    // PC write walking D, E, M, W.
    PCSrcD = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    PCSrcD = 1'b0; PCSrcE = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    PCSrcE = 1'b0; PCSrcM = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    PCSrcM = 1'b0; PCSrcW = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b100, 1'b0));
    clr();
    BranchTakenE = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0));

    // Memory wait of 3 cycles with concurrent branch and forwarding.
    doReset();
    MemReqM = 1'b1; BranchTakenE = 1'b1; RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    repeat (3) cyc(mk(2'b10, 2'b00, 4'b1111, 3'b001, 1'b0));
    MemReadyM = 1'b1;
    cyc(mk(2'b10, 2'b00, 4'b0000, 3'b110, 1'b0));
    clr();
    MemReqM = 1'b1; MemReadyM = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    clr();

    // Timeout: 4 stalled cycles, then sticky error with base controls.
    MemReqM = 1'b1;
    repeat (4) cyc(mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1));
    BranchTakenE = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b1));
    reset = 1'b0;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b1));
    reset = 1'b1; clr();
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    // Reset during WAIT abandons the wait; a fresh 3-cycle wait must not time out.
    MemReqM = 1'b1;
    repeat (2) cyc(mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    reset = 1'b0;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0));
    reset = 1'b1;
    repeat (3) cyc(mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    MemReadyM = 1'b1;
    cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    clr();

    // Counter saturation under continuous load-use stall.
    doReset();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd1;
    repeat (20) cyc(mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    clr();
    repeat (2) cyc(mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
